// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage for the miniRV core.
// Owns the fetch PC and drives a 1-cycle-latency IROM. Returned instructions
// are buffered as {pc, inst} pairs in a small FIFO that feeds ID over a
// valid/ready handshake. A redirect from EX flushes both the buffered entries
// and the in-flight fetch.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              IMEM_AW  = 14,
    parameter int              FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pc4
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    localparam logic [CW:0]     DEPTH_LIM  = (CW + 1)'(FQ_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE    = 1;
    localparam logic [CW-1:0]   CNT_ONE    = 1;
    localparam logic [XLEN-1:0] PC_STEP    = 4;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - 2){1'b1}}, 2'b00};

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] pc_q;
    logic            inflight;
    logic            kill;

    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
    logic [31:0]     inst_mem [FQ_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;

    // Handshake and credit decisions. The occupancy term counts the entry that
    // the outstanding fetch will deliver, so the FIFO can never overflow.
    always_comb begin
        out_valid = !rst && (count != '0);
        pop       = out_valid && out_ready;
        push      = inflight && !kill && !redirect_valid;
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue     = !rst && !redirect_valid && (occupancy < DEPTH_LIM);
    end

    assign imem_en   = issue;
    assign imem_addr = fpc[IMEM_AW+1:2];
    assign out_pc    = pc_mem[rd_ptr];
    assign out_inst  = inst_mem[rd_ptr];
    assign out_pc4   = out_pc + PC_STEP;

    // Fetch PC sequencing, in-flight tracking and the one-cycle response kill.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= RESET_PC;
            pc_q     <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= redirect_valid && issue;
            if (redirect_valid) begin
                fpc <= redirect_pc & ALIGN_MASK;
            end else if (issue) begin
                fpc  <= fpc + PC_STEP;
                pc_q <= fpc;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]   <= pc_q;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue with a queue-based
// reference model compared every cycle plus literal expectations per scenario.
module tb_if_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          IMEM_AW  = 14;
    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic               clk;
    logic               rst;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_pc4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: next fetch PC, one outstanding fetch, queue of PCs in
    // presentation order. Instructions follow from the PC via the IROM image.
    logic [31:0] m_fpc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_q[$];
    bit          model_live = 0;
    bit          watch40    = 0;
    bit          seen40     = 0;

    if_fetch_queue #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .FQ_DEPTH(FQ_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IROM image: word i holds i; garbage when not enabled.
    function automatic logic [31:0] irom(input logic [31:0] pc);
        return {18'b0, pc[15:2]};
    endfunction

    always @(posedge clk) begin
        imem_rdata <= imem_en ? {18'b0, imem_addr} : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_issue(input bit pop);
        return !rst && !redirect_valid && (m_q.size() + int'(m_pend) - int'(pop) < FQ_DEPTH);
    endfunction

    // Model update at the clock edge, from the stable inputs of the ending cycle.
    always @(posedge clk) begin
        bit pop;
        bit iss;
        if (rst) begin
            m_fpc      = RESET_PC;
            m_pend     = 0;
            m_q.delete();
            model_live = 1;
        end else if (model_live) begin
            pop = (m_q.size() > 0) && out_ready;
            iss = model_issue(pop);
            if (pop) void'(m_q.pop_front());
            if (redirect_valid) begin
                m_q.delete();
                m_fpc  = redirect_pc & 32'hFFFF_FFFC;
                m_pend = 0;
            end else begin
                if (m_pend) m_q.push_back(m_pend_pc);
                m_pend = iss;
                if (iss) begin
                    m_pend_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        bit ev;
        bit ee;
        if (model_live) begin
            ev = !rst && (m_q.size() > 0);
            ee = model_issue(ev && out_ready);
            checkOutput("m_out_valid", {31'b0, out_valid}, {31'b0, ev});
            checkOutput("m_imem_en", {31'b0, imem_en}, {31'b0, ee});
            if (ev && out_valid) begin
                checkOutput("m_out_pc", out_pc, m_q[0]);
                checkOutput("m_out_inst", out_inst, irom(m_q[0]));
                checkOutput("m_out_pc4", out_pc4, m_q[0] + 32'd4);
            end
            if (ee && imem_en) begin
                checkOutput("m_imem_addr", {18'b0, imem_addr}, {18'b0, m_fpc[15:2]});
            end
            if (watch40 && out_valid && out_pc == 32'h40) seen40 = 1;
        end
    end

    // One cycle: drive inputs just after the edge, return mid-cycle.
    task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst            = r;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_imem_en", {31'b0, imem_en}, 32'd0);

        // Scenario 1: release reset; cycle 0 issues RESET_PC.
        cyc = -1;
        applyStimulus(0, 1, 0, 0);
        checkOutput("c0_imem_en", {31'b0, imem_en}, 32'd1);
        checkOutput("c0_imem_addr", {18'b0, imem_addr}, 32'd0);
        checkOutput("c0_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c1_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c2_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("c2_out_pc", out_pc, 32'h0);
        checkOutput("c2_out_inst", out_inst, 32'h0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c3_out_pc", out_pc, 32'h4);
        checkOutput("c3_out_inst", out_inst, 32'h1);
        checkOutput("c3_out_pc4", out_pc4, 32'h8);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c4_out_pc", out_pc, 32'h8);

        // Scenario 2: stall cycles 5..10, entry 0xC held, no fetch issued.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("stall_out_pc", out_pc, 32'hC);
            checkOutput("stall_out_inst", out_inst, 32'h3);
            checkOutput("stall_imem_en", {31'b0, imem_en}, 32'd0);
        end
        applyStimulus(0, 1, 0, 0);
        checkOutput("c11_out_pc", out_pc, 32'hC);
        checkOutput("c11_imem_addr", {18'b0, imem_addr}, 32'd5);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c12_out_pc", out_pc, 32'h10);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c13_out_pc", out_pc, 32'h14);

        // Scenario 3: redirect to 0x103 with a fetch returning in the same cycle.
        applyStimulus(0, 0, 1, 32'h0000_0103);
        checkOutput("c14_out_pc", out_pc, 32'h18);
        checkOutput("c14_imem_en", {31'b0, imem_en}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c15_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("c15_imem_addr", {18'b0, imem_addr}, 32'h40);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c16_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c17_out_pc", out_pc, 32'h100);
        checkOutput("c17_out_inst", out_inst, 32'h40);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c18_out_pc", out_pc, 32'h104);

        // Scenario 4: back-to-back redirects, the second wins.
        watch40 = 1;
        applyStimulus(0, 1, 1, 32'h40);
        applyStimulus(0, 1, 1, 32'h80);
        checkOutput("c20_imem_en", {31'b0, imem_en}, 32'd0);
        checkOutput("c20_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c21_imem_addr", {18'b0, imem_addr}, 32'h20);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c22_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c23_out_pc", out_pc, 32'h80);
        applyStimulus(0, 1, 0, 0);
        checkOutput("c24_out_pc", out_pc, 32'h84);
        watch40 = 0;
        checkOutput("never_0x40", {31'b0, seen40}, 32'd0);

        // Scenario 5: redirect to the top of the address space and wrap.
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_out_pc4", out_pc4, 32'h0);
        checkOutput("wrap_out_inst", out_inst, 32'h3FFF);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_next_pc", out_pc, 32'h0);
        checkOutput("wrap_next_inst", out_inst, 32'h0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_stream_valid", {31'b0, out_valid}, 32'd1);

        // Scenario 6: reset mid-stream, then restart at RESET_PC.
        applyStimulus(1, 1, 0, 0);
        checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_imem_en", {31'b0, imem_en}, 32'd0);
        applyStimulus(1, 1, 1, 32'h200);
        checkOutput("mid_rst2_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("restart_imem_addr", {18'b0, imem_addr}, 32'd0);
        checkOutput("restart_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("restart_out_pc", out_pc, RESET_PC);
        applyStimulus(0, 1, 0, 0);
        checkOutput("restart_next_pc", out_pc, RESET_PC + 32'd4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
